ram_port_arbiter: RTL and testbench

- Two-requester round-robin arbiter sharing the single-port Data_Memory_RAM (clock, data, address, wren, q).
- Issues at most one RAM access per cycle.
- Returns read data to the requester that issued the read, tagged with a valid strobe, after a fixed read latency.
- Sits between the requesting blocks (or the input driver in the bench) and the RAM instance.

---
 rtl/ram_port_arbiter_if.sv | 24 ++
 rtl/ram_port_arbiter.sv | 103 ++++++++++
 tb/tb_ram_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: one requester's access port to the shared RAM.
// The master side issues req/we/addr/wdata; the slave answers gnt and read data.
interface ram_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of one single-port RAM by two requesters.
// Define ARB_PERF_COUNT_EN to add saturating grant/conflict counters.
module ram_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  ram_port_arbiter_if.slave     rq0,
  ram_port_arbiter_if.slave     rq1,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q
`ifdef ARB_PERF_COUNT_EN
  ,
  output logic [15:0]           gnt_cnt0,
  output logic [15:0]           gnt_cnt1,
  output logic [15:0]           conflict_cnt
`endif
);

  localparam int RL = READ_LATENCY;

  logic          last_gnt;
  logic          g0;
  logic          g1;
  logic          push;
  logic [RL-1:0] pv;
  logic [RL-1:0] pid;

  // Under contention the requester that did not win last time goes.
  always_comb begin
    g0 = reset & rq0.req & (~rq1.req | last_gnt);
    g1 = reset & rq1.req & (~rq0.req | ~last_gnt);
  end

  assign rq0.gnt = g0;
  assign rq1.gnt = g1;

  always_comb begin
    ram_address = rq0.addr;
    ram_data    = rq0.wdata;
    if (g1) begin
      ram_address = rq1.addr;
      ram_data    = rq1.wdata;
    end
    ram_wren = (g0 & rq0.we) | (g1 & rq1.we);
    push     = (g0 & ~rq0.we) | (g1 & ~rq1.we);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_gnt <= 1'b1;
    end else if (g0) begin
      last_gnt <= 1'b0;
    end else if (g1) begin
      last_gnt <= 1'b1;
    end
  end

  // Read tags travel alongside the RAM's own latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pv  <= '0;
      pid <= '0;
    end else begin
      pv[0]  <= push;
      pid[0] <= g1;
      for (int i = 1; i < RL; i++) begin
        pv[i]  <= pv[i-1];
        pid[i] <= pid[i-1];
      end
    end
  end

  assign rq0.rvalid = pv[RL-1] & ~pid[RL-1];
  assign rq1.rvalid = pv[RL-1] & pid[RL-1];
  assign rq0.rdata  = ram_q;
  assign rq1.rdata  = ram_q;

`ifdef ARB_PERF_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_cnt0     <= '0;
      gnt_cnt1     <= '0;
      conflict_cnt <= '0;
    end else begin
      if (g0 && gnt_cnt0 != 16'hFFFF) begin
        gnt_cnt0 <= gnt_cnt0 + 16'd1;
      end
      if (g1 && gnt_cnt1 != 16'hFFFF) begin
        gnt_cnt1 <= gnt_cnt1 + 16'd1;
      end
      if (rq0.req && rq1.req && conflict_cnt != 16'hFFFF) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: random and directed traffic against a queue-based model.
// Grants are predicted per cycle; read returns are matched by a separate monitor.
module tb_ram_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int RL = 2;

  typedef struct {
    bit             idle;
    bit             we;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
  } cmd_t;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic [DW-1:0] ram_q;
`ifdef ARB_PERF_COUNT_EN
  logic [15:0] gnt_cnt0;
  logic [15:0] gnt_cnt1;
  logic [15:0] conflict_cnt;
  int rc0 = 0;
  int rc1 = 0;
  int rcc = 0;
`endif

  ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rq0 ();
  ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rq1 ();

  ram_port_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .READ_LATENCY(RL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rq0(rq0),
    .rq1(rq1),
    .ram_address(ram_address),
    .ram_data(ram_data),
    .ram_wren(ram_wren),
    .ram_q(ram_q)
`ifdef ARB_PERF_COUNT_EN
    ,
    .gnt_cnt0(gnt_cnt0),
    .gnt_cnt1(gnt_cnt1),
    .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // RAM: address registered at the edge, q optionally registered further.
  logic [DW-1:0] mem [0:255];
  logic [AW-1:0] a_q;
  logic [DW-1:0] qr [0:3];

  always @(posedge clk) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    a_q <= ram_address;
    qr[0] <= mem[a_q];
    for (int i = 1; i < 4; i++) qr[i] <= qr[i-1];
  end

  if (RL == 1) begin : g_q1
    assign ram_q = mem[a_q];
  end else begin : g_qn
    assign ram_q = qr[RL-2];
  end

  logic [DW-1:0] ref_mem [0:255];
  cmd_t q0 [$];
  cmd_t q1 [$];
  exp_t exp_q [$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   mlast = 1;
  bit   took0 = 0;
  bit   took1 = 0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    rq0.req = 0; rq0.we = 0; rq0.addr = '0; rq0.wdata = '0;
    rq1.req = 0; rq1.we = 0; rq1.addr = '0; rq1.wdata = '0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Driver: hold each command until the grant was seen, then take the next.
  always @(posedge clk) begin
    cmd_t c;
    #1;
    if (!rq0.req || took0) begin
      if (q0.size() == 0) rq0.req = 0;
      else begin
        c = q0.pop_front();
        rq0.req = !c.idle; rq0.we = c.we;
        rq0.addr = c.addr; rq0.wdata = c.data;
      end
    end
    if (!rq1.req || took1) begin
      if (q1.size() == 0) rq1.req = 0;
      else begin
        c = q1.pop_front();
        rq1.req = !c.idle; rq1.we = c.we;
        rq1.addr = c.addr; rq1.wdata = c.data;
      end
    end
  end

  // Grant predictor and RAM-drive checker.
  always @(negedge clk) begin
    int win;
    bit w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    if (!reset) begin
      took0 = 0; took1 = 0; mlast = 1;
      exp_q.delete();
`ifdef ARB_PERF_COUNT_EN
      rc0 = 0; rc1 = 0; rcc = 0;
`endif
      checks++;
      if (rq0.gnt || rq1.gnt || rq0.rvalid || rq1.rvalid) begin
        failures++;
        $display("FAIL reset_quiet gnt=%b%b rvalid=%b%b required all 0",
                 rq0.gnt, rq1.gnt, rq0.rvalid, rq1.rvalid);
      end
    end else begin
      win = -1;
      if (rq0.req && rq1.req) win = 1 - mlast;
      else if (rq0.req) win = 0;
      else if (rq1.req) win = 1;
      checks++;
      if (rq0.gnt !== (win == 0) || rq1.gnt !== (win == 1)) begin
        failures++;
        $display("FAIL grant cyc=%0d gnt0=%b gnt1=%b required winner=%0d",
                 cyc, rq0.gnt, rq1.gnt, win);
      end
      took0 = rq0.gnt;
      took1 = rq1.gnt;
`ifdef ARB_PERF_COUNT_EN
      if (rq0.req && rq1.req && rcc < 65535) rcc++;
      if (win == 0 && rc0 < 65535) rc0++;
      if (win == 1 && rc1 < 65535) rc1++;
`endif
      if (win >= 0) begin
        w_we   = (win == 0) ? rq0.we : rq1.we;
        w_addr = (win == 0) ? rq0.addr : rq1.addr;
        w_data = (win == 0) ? rq0.wdata : rq1.wdata;
        checks++;
        if (ram_wren !== w_we || ram_address !== w_addr ||
            (w_we && ram_data !== w_data)) begin
          failures++;
          $display("FAIL ram_drive cyc=%0d wren=%b addr=%h data=%h required %b %h %h",
                   cyc, ram_wren, ram_address, ram_data, w_we, w_addr, w_data);
        end
        if (w_we) ref_mem[w_addr] = w_data;
        else exp_q.push_back('{win, ref_mem[w_addr], cyc + RL});
        mlast = win;
      end else begin
        checks++;
        if (ram_wren !== 1'b0) begin
          failures++;
          $display("FAIL idle_wren cyc=%0d wren=%b required 0", cyc, ram_wren);
        end
      end
    end
  end

  // Read-return monitor.
  always @(negedge clk) begin
    exp_t e;
    int gid;
    logic [DW-1:0] gd;
    if (reset) begin
      if (rq0.rvalid || rq1.rvalid) begin
        checks++;
        gid = rq1.rvalid ? 1 : 0;
        gd  = rq1.rvalid ? rq1.rdata : rq0.rdata;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rvalid_unexpected cyc=%0d rvalid=%b%b required none",
                   cyc, rq0.rvalid, rq1.rvalid);
        end else begin
          e = exp_q.pop_front();
          if ((rq0.rvalid && rq1.rvalid) || gid != e.id ||
              gd !== e.data || cyc != e.due) begin
            failures++;
            $display("FAIL read_return cyc=%0d id=%0d data=%h required cyc=%0d id=%0d data=%h",
                     cyc, gid, gd, e.due, e.id, e.data);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        checks++;
        failures++;
        $display("FAIL read_missing cyc=%0d required id=%0d at cyc=%0d",
                 cyc, exp_q[0].id, exp_q[0].due);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic wait_idle(input int limit);
    bit done;
    done = 0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      done = q0.size() == 0 && q1.size() == 0 && !rq0.req &&
             !rq1.req && exp_q.size() == 0;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL timeout idle not reached within %0d cycles", limit);
    end
  endtask

  function automatic cmd_t rd(input logic [AW-1:0] a);
    return '{1'b0, 1'b0, a, '0};
  endfunction

  function automatic cmd_t wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    return '{1'b0, 1'b1, a, d};
  endfunction

  initial begin
    cmd_t idle_c;
    idle_c = '{1'b1, 1'b0, '0, '0};
    repeat (3) @(posedge clk);
    #2 reset = 1;

    q0.push_back(wr(8'h10, 32'hDEAD_BEEF));
    q0.push_back(rd(8'h10));
    wait_idle(50);

    for (int i = 0; i < 3; i++) begin
      q0.push_back(rd(8'h01));
      q1.push_back(rd(8'h02));
    end
    wait_idle(50);

    for (int i = 0; i < 8; i++) q1.push_back(rd(AW'(i)));
    wait_idle(50);

    q0.push_back(rd(8'h30));
    q0.push_back(rd(8'h20));
    q1.push_back(idle_c);
    q1.push_back(wr(8'h20, 32'h1234_5678));
    wait_idle(50);

    q0.push_back(rd(8'h10));
    for (int i = 0; i < 20 && !took0; i++) @(negedge clk);
    checks++;
    if (!took0) begin
      failures++;
      $display("FAIL reset_read_grant gnt0=0 required 1");
    end
    @(posedge clk);
    #2 reset = 0;
    repeat (2) @(posedge clk);
    #2 reset = 1;
    q0.push_back(rd(8'h01));
    q1.push_back(rd(8'h02));
    wait_idle(50);

    for (int i = 0; i < 400; i++) begin
      q0.push_back('{($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                     AW'($urandom_range(0, 15)), DW'($urandom)});
      q1.push_back('{($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                     AW'($urandom_range(0, 15)), DW'($urandom)});
    end
    wait_idle(3000);

`ifdef ARB_PERF_COUNT_EN
    for (int i = 0; i < 65540; i++) q0.push_back(rd(8'h03));
    wait_idle(70000);
    checks++;
    if (gnt_cnt0 !== 16'(rc0) || gnt_cnt1 !== 16'(rc1) ||
        conflict_cnt !== 16'(rcc)) begin
      failures++;
      $display("FAIL perf_counters got %0d %0d %0d required %0d %0d %0d",
               gnt_cnt0, gnt_cnt1, conflict_cnt, rc0, rc1, rcc);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
